if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the MIPS5 pipeline: PC register, ROM fetch interface and IF/ID pipeline register in one block.
- Sits between inst_rom (asynchronous read) and the ID stage.
- Handles sequential fetch, delayed branches/jumps (one delay slot), pipeline stalls, and exception flush.
- A branch that arrives during a stall is held pending until the stall clears.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- NOP_INST, 32'h00000000, instruction word injected as a bubble.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- stall_if  input  1  hold PC; no new fetch accepted.
- stall_id  input  1  hold the IF/ID register.
- branch_flag_i  input  1  ID resolved a taken branch/jump this cycle.
- branch_target_i  input  32  target of the taken branch.
- flush_i  input  1  exception/eret flush from CTRL.
- flush_pc_i  input  32  handler or return address on flush.
- rom_data_i  input  32  instruction word from inst_rom at rom_addr_o (combinational).
- rom_addr_o  output  32  fetch address (equals pc).
- rom_ce_o  output  1  ROM chip enable.
- id_pc_o  output  32  PC of the instruction in IF/ID.
- id_inst_o  output  32  instruction in IF/ID.
- id_valid_o  output  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (rst=1 at an edge): pc<=RESET_PC, rom_ce_o<=0, id_pc_o<=0, id_inst_o<=NOP_INST, id_valid_o<=0, pending<=0, pend_target<=0. Reset applied mid-operation discards any pending branch.
- rom_ce_o rises on the first edge with rst=0. While rom_ce_o=0, pc stays RESET_PC and IF/ID loads a bubble.
- rom_addr_o = pc (combinational). Fetch latency: the word at address A appears on id_inst_o one edge after pc=A.
- PC next-state priority, highest first, evaluated at each edge with rom_ce_o=1:
  - flush_i: pc<=flush_pc_i; clear pending.
  - stall_if: pc holds; if branch_flag_i, set pending<=1 and pend_target<=branch_target_i.
  - pending: pc<=pend_target; clear pending.
  - branch_flag_i: pc<=branch_target_i.
  - otherwise: pc<=pc+4 (32-bit wrap, 32'hFFFFFFFC -> 32'h00000000).
- Delay slot: the instruction at branch_pc+4 is already in IF when branch_flag_i is asserted. It is latched normally and is not squashed. The target is fetched on the following cycle.
- IF/ID register, priority highest first:
  - flush_i: load bubble (id_inst_o=NOP_INST, id_valid_o=0, id_pc_o=0).
  - stall_id: hold all IF/ID outputs.
  - stall_if (and not stall_id): load bubble.
  - otherwise: id_pc_o<=pc, id_inst_o<=rom_data_i, id_valid_o<=1.
- Simultaneous events:
  - flush_i with branch_flag_i: the flush wins and the branch is dropped.
  - stall_if with a pending branch already set: a new branch_flag_i overwrites pend_target; the last one wins.
- The stall pattern is legal only if stall_id implies stall_if. If stall_id=1 and stall_if=0, behaviour is undefined and the bench asserts on it.

Test Plan:
- Reset held 10 cycles, then released, ROM words 0x34010001, 0x34010002, ... -> rom_ce_o=1 one edge after release; id_pc_o sequence 0, 4, 8, ...; id_valid_o=1 from the second edge after release.
- Jump at pc=0x8 (ID raises branch_flag_i with target 0x40 when id_pc_o=0x8) -> id_pc_o sequence 0x8, 0xC (delay slot, valid=1), 0x40, 0x44.
- stall_if=1, stall_id=0 for 2 cycles with pc=0x10 -> pc holds 0x10; id_valid_o=0 for 2 cycles; then id_pc_o=0x10.
- stall_if=1 and stall_id=1 for 3 cycles -> id_pc_o/id_inst_o unchanged; pc unchanged.
- branch_flag_i=1 (target 0x100) during stall_if=1, released next cycle -> pc=0x100 on the first unstalled edge; the pending flag clears.
- flush_i=1 with flush_pc_i=0x20 and branch_flag_i=1 (target 0x80) in the same cycle -> pc=0x20; IF/ID holds a bubble; the next id_pc_o is 0x20.
- Wrap case: pc=0xFFFFFFFC with no stall -> next pc=0x00000000.
- rst asserted while pending=1 -> after reset, fetch restarts at RESET_PC with no redirect.

Source files
------------

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: PC register, ROM fetch interface and the IF/ID
// pipeline register. Supports sequential fetch, delayed branches (one delay
// slot, never squashed), stalls, exception flush, and a branch that arrives
// during an IF stall being held pending until the stall clears.
//
// Ports
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   stall_if         hold PC, accept no new fetch
//   stall_id         hold the IF/ID register (only legal together with stall_if)
//   branch_flag_i    ID resolved a taken branch/jump this cycle
//   branch_target_i  target of that branch
//   flush_i          exception/eret flush
//   flush_pc_i       handler or return address used on flush
//   rom_data_i       instruction word at rom_addr_o (combinational ROM)
//   rom_addr_o       fetch address (the PC)
//   rom_ce_o         ROM chip enable, rises on the first edge out of reset
//   id_pc_o          PC of the instruction held in IF/ID
//   id_inst_o        instruction held in IF/ID
//   id_valid_o       IF/ID holds a real instruction (0 = bubble)
// ----------------------------------------------------------------------------
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_if,
   input  logic        stall_id,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   input  logic [31:0] rom_data_i,
   output logic [31:0] rom_addr_o,
   output logic        rom_ce_o,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_inst_o,
   output logic        id_valid_o
);

   logic [31:0] pc;
   logic        pending;
   logic [31:0] pend_target;

   assign rom_addr_o = pc;

   // PC, pending branch and ROM enable
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         rom_ce_o    <= 1'b0;
         pending     <= 1'b0;
         pend_target <= 32'h0;
      end else if (!rom_ce_o) begin
         // first cycle out of reset: enable the ROM, fetch has not started yet
         rom_ce_o    <= 1'b1;
         pc          <= RESET_PC;
         pending     <= 1'b0;
      end else if (flush_i) begin
         // a flush also drops any branch resolved in the same cycle
         pc          <= flush_pc_i;
         pending     <= 1'b0;
      end else if (stall_if) begin
         // PC holds; remember the most recent branch seen during the stall
         if (branch_flag_i) begin
            pending     <= 1'b1;
            pend_target <= branch_target_i;
         end
      end else if (pending) begin
         pc          <= pend_target;
         pending     <= 1'b0;
      end else if (branch_flag_i) begin
         // delay slot at pc is latched into IF/ID this edge, target fetched next
         pc          <= branch_target_i;
      end else begin
         pc          <= pc + 32'd4;
      end
   end

   // IF/ID pipeline register
   always_ff @(posedge clk) begin
      if (rst || !rom_ce_o || flush_i) begin
         id_pc_o    <= 32'h0;
         id_inst_o  <= NOP_INST;
         id_valid_o <= 1'b0;
      end else if (stall_id) begin
         id_pc_o    <= id_pc_o;
         id_inst_o  <= id_inst_o;
         id_valid_o <= id_valid_o;
      end else if (stall_if) begin
         id_pc_o    <= 32'h0;
         id_inst_o  <= NOP_INST;
         id_valid_o <= 1'b0;
      end else begin
         id_pc_o    <= pc;
         id_inst_o  <= rom_data_i;
         id_valid_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst, stall_if, stall_id, branch_flag_i, flush_i;
   logic [31:0] branch_target_i, flush_pc_i, rom_data_i;
   logic [31:0] rom_addr_o, id_pc_o, id_inst_o;
   logic        rom_ce_o, id_valid_o;

   int checks = 0;
   int failures = 0;

   // reference model state
   logic [31:0] m_pc, m_pt, m_id_pc, m_id_inst;
   logic        m_ce, m_pend, m_id_valid;

   if_stage #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
      .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id),
      .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
      .flush_i(flush_i), .flush_pc_i(flush_pc_i), .rom_data_i(rom_data_i),
      .rom_addr_o(rom_addr_o), .rom_ce_o(rom_ce_o), .id_pc_o(id_pc_o),
      .id_inst_o(id_inst_o), .id_valid_o(id_valid_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      return 32'h3401_0001 + (a >> 2);
   endfunction

   assign rom_data_i = rom(rom_addr_o);

   always @(posedge clk)
      if (rst !== 1'b1)
         assert (!(stall_id && !stall_if)) else $error("illegal stall pattern driven");

   task automatic idle();
      rst = 0; stall_if = 0; stall_id = 0; branch_flag_i = 0; flush_i = 0;
      branch_target_i = 32'h0; flush_pc_i = 32'h0;
   endtask

   // advance one edge, update the reference model from the applied inputs
   task automatic tick();
      logic [31:0] old_pc;
      @(posedge clk);
      old_pc = m_pc;
      if (rst) begin
         m_ce = 0; m_pc = 32'h0; m_pend = 0; m_pt = 0;
         m_id_pc = 0; m_id_inst = NOP; m_id_valid = 0;
      end else if (!m_ce) begin
         m_ce = 1; m_id_pc = 0; m_id_inst = NOP; m_id_valid = 0;
      end else begin
         if (flush_i || (stall_if && !stall_id)) begin
            m_id_pc = 0; m_id_inst = NOP; m_id_valid = 0;
         end else if (!stall_id) begin
            m_id_pc = old_pc; m_id_inst = rom(old_pc); m_id_valid = 1;
         end
         if (flush_i) begin
            m_pc = flush_pc_i; m_pend = 0;
         end else if (stall_if) begin
            if (branch_flag_i) begin m_pend = 1; m_pt = branch_target_i; end
         end else if (m_pend) begin
            m_pc = m_pt; m_pend = 0;
         end else if (branch_flag_i) m_pc = branch_target_i;
         else m_pc = old_pc + 32'd4;
      end
      #1;
   endtask

   task automatic test_reset();
      idle(); rst = 1;
      repeat (10) tick();
      checks++; if (rom_ce_o !== 1'b0) begin failures++; $display("FAIL reset_ce got=%b exp=0", rom_ce_o); end
      checks++; if (rom_addr_o !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", rom_addr_o); end
      checks++; if (id_valid_o !== 1'b0 || id_inst_o !== NOP || id_pc_o !== 32'h0) begin
         failures++; $display("FAIL reset_ifid got v=%b pc=%h inst=%h exp bubble", id_valid_o, id_pc_o, id_inst_o); end
      idle(); tick();
      checks++; if (rom_ce_o !== 1'b1 || id_valid_o !== 1'b0 || rom_addr_o !== 32'h0) begin
         failures++; $display("FAIL release_first_edge got ce=%b v=%b pc=%h exp ce=1 v=0 pc=0", rom_ce_o, id_valid_o, rom_addr_o); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (id_valid_o !== 1'b1 || id_pc_o !== 32'(i*4) || id_inst_o !== 32'h3401_0001 + 32'(i)) begin
            failures++; $display("FAIL seq_fetch[%0d] got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h",
                                 i, id_valid_o, id_pc_o, id_inst_o, 32'(i*4), 32'h3401_0001 + 32'(i)); end
      end
   endtask

   task automatic test_jump();
      // id_pc=0x8 now: ID resolves the jump, delay slot 0xC is in IF
      branch_flag_i = 1; branch_target_i = 32'h40; tick(); idle();
      checks++; if (id_pc_o !== 32'hC || id_valid_o !== 1'b1 || id_inst_o !== 32'h3401_0004) begin
         failures++; $display("FAIL jump_delay_slot got pc=%h v=%b inst=%h exp pc=c v=1 inst=34010004", id_pc_o, id_valid_o, id_inst_o); end
      checks++; if (rom_addr_o !== 32'h40) begin failures++; $display("FAIL jump_target_fetch got=%h exp=40", rom_addr_o); end
      tick();
      checks++; if (id_pc_o !== 32'h40 || id_inst_o !== 32'h3401_0011) begin
         failures++; $display("FAIL jump_target_id got pc=%h inst=%h exp pc=40 inst=34010011", id_pc_o, id_inst_o); end
      tick();
      checks++; if (id_pc_o !== 32'h44) begin failures++; $display("FAIL jump_after_target got=%h exp=44", id_pc_o); end
   endtask

   task automatic test_stall_if();
      flush_i = 1; flush_pc_i = 32'h10; tick(); idle();
      checks++; if (rom_addr_o !== 32'h10 || id_valid_o !== 1'b0) begin
         failures++; $display("FAIL flush_to_10 got pc=%h v=%b exp pc=10 v=0", rom_addr_o, id_valid_o); end
      for (int i = 0; i < 2; i++) begin
         stall_if = 1; tick();
         checks++; if (rom_addr_o !== 32'h10 || id_valid_o !== 1'b0) begin
            failures++; $display("FAIL stall_if_hold[%0d] got pc=%h v=%b exp pc=10 v=0", i, rom_addr_o, id_valid_o); end
      end
      idle(); tick();
      checks++; if (id_pc_o !== 32'h10 || id_valid_o !== 1'b1 || rom_addr_o !== 32'h14) begin
         failures++; $display("FAIL stall_if_release got id_pc=%h v=%b pc=%h exp 10 1 14", id_pc_o, id_valid_o, rom_addr_o); end
   endtask

   task automatic test_stall_both();
      for (int i = 0; i < 3; i++) begin
         stall_if = 1; stall_id = 1; tick();
         checks++; if (id_pc_o !== 32'h10 || id_inst_o !== 32'h3401_0005 || id_valid_o !== 1'b1 || rom_addr_o !== 32'h14) begin
            failures++; $display("FAIL stall_both[%0d] got id_pc=%h inst=%h v=%b pc=%h exp 10 34010005 1 14",
                                 i, id_pc_o, id_inst_o, id_valid_o, rom_addr_o); end
      end
      idle(); tick();
      checks++; if (id_pc_o !== 32'h14) begin failures++; $display("FAIL stall_both_release got=%h exp=14", id_pc_o); end
   endtask

   task automatic test_pending();
      // pc=0x18 here
      stall_if = 1; branch_flag_i = 1; branch_target_i = 32'h100; tick(); idle();
      checks++; if (rom_addr_o !== 32'h18 || id_valid_o !== 1'b0) begin
         failures++; $display("FAIL pend_hold got pc=%h v=%b exp 18 0", rom_addr_o, id_valid_o); end
      tick();
      checks++; if (rom_addr_o !== 32'h100 || id_pc_o !== 32'h18) begin
         failures++; $display("FAIL pend_redirect got pc=%h id_pc=%h exp 100 18", rom_addr_o, id_pc_o); end
      tick();
      checks++; if (rom_addr_o !== 32'h104 || id_pc_o !== 32'h100) begin
         failures++; $display("FAIL pend_cleared got pc=%h id_pc=%h exp 104 100", rom_addr_o, id_pc_o); end
      stall_if = 1; branch_flag_i = 1; branch_target_i = 32'h200; tick();
      branch_target_i = 32'h300; tick(); idle(); tick();
      checks++; if (rom_addr_o !== 32'h300) begin failures++; $display("FAIL pend_last_wins got=%h exp=300", rom_addr_o); end
   endtask

   task automatic test_flush_branch();
      flush_i = 1; flush_pc_i = 32'h20; branch_flag_i = 1; branch_target_i = 32'h80; tick(); idle();
      checks++; if (rom_addr_o !== 32'h20 || id_valid_o !== 1'b0 || id_pc_o !== 32'h0 || id_inst_o !== NOP) begin
         failures++; $display("FAIL flush_branch got pc=%h v=%b id_pc=%h inst=%h exp 20 0 0 nop", rom_addr_o, id_valid_o, id_pc_o, id_inst_o); end
      tick();
      checks++; if (id_pc_o !== 32'h20 || rom_addr_o !== 32'h24) begin
         failures++; $display("FAIL flush_next got id_pc=%h pc=%h exp 20 24", id_pc_o, rom_addr_o); end
   endtask

   task automatic test_wrap();
      flush_i = 1; flush_pc_i = 32'hFFFF_FFFC; tick(); idle(); tick();
      checks++; if (rom_addr_o !== 32'h0 || id_pc_o !== 32'hFFFF_FFFC) begin
         failures++; $display("FAIL wrap got pc=%h id_pc=%h exp 0 fffffffc", rom_addr_o, id_pc_o); end
   endtask

   task automatic test_reset_pending();
      stall_if = 1; branch_flag_i = 1; branch_target_i = 32'h500; tick(); idle();
      rst = 1; tick(); tick(); idle(); tick(); tick();
      checks++; if (rom_addr_o !== 32'h4 || id_pc_o !== 32'h0 || id_valid_o !== 1'b1) begin
         failures++; $display("FAIL reset_drops_pending got pc=%h id_pc=%h v=%b exp 4 0 1", rom_addr_o, id_pc_o, id_valid_o); end
   endtask

   task automatic test_random();
      int errs = 0;
      for (int i = 0; i < 400; i++) begin
         idle();
         rst           = ($urandom_range(0, 99) == 0);
         stall_if      = ($urandom_range(0, 3) == 0);
         stall_id      = stall_if && ($urandom_range(0, 1) == 1);
         branch_flag_i = ($urandom_range(0, 4) == 0);
         branch_target_i = {$urandom_range(0, 32'h3FFF), 2'b00};
         flush_i       = ($urandom_range(0, 15) == 0);
         flush_pc_i    = {$urandom(), 2'b00} >> 0;
         flush_pc_i[1:0] = 2'b00;
         tick();
         checks++;
         if (rom_addr_o !== m_pc || rom_ce_o !== m_ce || id_pc_o !== m_id_pc ||
             id_inst_o !== m_id_inst || id_valid_o !== m_id_valid) begin
            failures++; errs++;
            if (errs <= 10)
               $display("FAIL random[%0d] got pc=%h ce=%b id_pc=%h inst=%h v=%b exp pc=%h ce=%b id_pc=%h inst=%h v=%b",
                        i, rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o,
                        m_pc, m_ce, m_id_pc, m_id_inst, m_id_valid);
         end
      end
      idle();
   endtask

   initial begin
      m_pc = 0; m_pt = 0; m_id_pc = 0; m_id_inst = NOP; m_ce = 0; m_pend = 0; m_id_valid = 0;
      idle(); rst = 1;
      #1;
      test_reset();
      test_jump();
      test_stall_if();
      test_stall_both();
      test_pending();
      test_flush_branch();
      test_wrap();
      test_reset_pending();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
